alarm_time_setter: RTL and testbench



---
 rtl/alarm_time_setter_pkg.sv | 30 +++
 rtl/alarm_time_setter_if.sv | 25 ++
 rtl/alarm_time_setter_bcd2_wrap_step.sv | 39 +++
 rtl/alarm_time_setter.sv | 157 +++++++++++++++
 tb/tb_alarm_time_setter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_time_setter_pkg.sv
// Shared codes for the alarm-time setter: alarm_check state codes, edit-field codes, BCD limits.
package alarm_time_setter_pkg;

  localparam int SWIDTH = 3;

  localparam logic [SWIDTH-1:0] S0 = 3'b000;
  localparam logic [SWIDTH-1:0] S1 = 3'b001;
  localparam logic [SWIDTH-1:0] S2 = 3'b010;
  localparam logic [SWIDTH-1:0] S3 = 3'b100;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  typedef enum logic [1:0] {
    IDLE,
    EDIT_H,
    EDIT_M,
    COMMIT
  } set_state_t;

  // Ringing (S2) or minigame (S3) freezes all editing.
  function automatic logic is_locked(input logic [SWIDTH-1:0] st);
    return (st == S2) || (st == S3);
  endfunction

endpackage

// File: rtl/alarm_time_setter_if.sv
// Button/alarm-state inputs and alarm/edit outputs of the alarm-time setter.
interface alarm_time_setter_if;
  import alarm_time_setter_pkg::*;

  logic              set_en;
  logic              push_sel;
  logic              push_up;
  logic              push_down;
  logic [SWIDTH-1:0] alarm_state;
  logic [15:0]       alarm;
  logic [15:0]       edit_value;
  logic [1:0]        edit_field;
  logic              commit;

  modport master (
    output set_en, push_sel, push_up, push_down, alarm_state,
    input  alarm, edit_value, edit_field, commit
  );

  modport slave (
    input  set_en, push_sel, push_up, push_down, alarm_state,
    output alarm, edit_value, edit_field, commit
  );

endinterface

// File: rtl/alarm_time_setter_bcd2_wrap_step.sv
// Combinational two-digit BCD +/-1 with wrap between 00 and max_value.
// An illegal input (bad digit or above max_value) steps to 00; no step leaves the value untouched.
module bcd2_wrap_step (
  input  logic [7:0] value,
  input  logic [7:0] max_value,
  input  logic       up,
  input  logic       down,
  output logic [7:0] next_value
);

  logic legal;

  // Valid BCD orders the same as plain binary, so a direct compare against max works.
  assign legal = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max_value);

  always_comb begin
    next_value = value;
    if (up ^ down) begin
      if (!legal) begin
        next_value = 8'h00;
      end else if (up) begin
        if (value == max_value)
          next_value = 8'h00;
        else if (value[3:0] == 4'd9)
          next_value = {value[7:4] + 4'd1, 4'd0};
        else
          next_value = value + 8'd1;
      end else begin
        if (value == 8'h00)
          next_value = max_value;
        else if (value[3:0] == 4'd0)
          next_value = {value[7:4] - 4'd1, 4'd9};
        else
          next_value = value - 8'd1;
      end
    end
  end

endmodule

// File: rtl/alarm_time_setter.sv
// Writes the alarm register from push buttons via a shadow copy committed on leaving edit mode.
// ALARM_AUTO_REPEAT_EN adds hold-to-repeat stepping for the up/down buttons.
module alarm_time_setter
  import alarm_time_setter_pkg::*;
#(
  parameter logic [15:0] RESET_ALARM   = 16'h0700,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned REPEAT_CYCLES = 4
) (
  input  logic               s2clk,
  input  logic               reset,
  alarm_time_setter_if.slave bus
);

  set_state_t  state;
  logic [15:0] alarm_q;
  logic [15:0] shadow_q;
  logic [1:0]  field_q;
  logic        commit_q;
  logic        sel_d, up_d, down_d;

  logic        lock, editing;
  logic        sel_ev, up_ev, down_ev;
  logic        up_rep, down_rep;
  logic        step_up, step_down;
  logic [7:0]  hour_next, min_next;

  assign lock    = is_locked(bus.alarm_state);
  assign editing = (state == EDIT_H) || (state == EDIT_M);
  assign sel_ev  = bus.push_sel  & ~sel_d;
  assign up_ev   = bus.push_up   & ~up_d;
  assign down_ev = bus.push_down & ~down_d;

`ifdef ALARM_AUTO_REPEAT_EN
  localparam int unsigned WRAP = HOLD_CYCLES + REPEAT_CYCLES - 1;
  localparam int CW = $clog2(WRAP + 1) + 1;

  logic [CW-1:0] up_cnt, down_cnt;
  logic          rep_clr;

  assign rep_clr = lock | sel_ev | ~editing;

  // Counter runs 0..HOLD, then cycles HOLD..HOLD+REPEAT-1; each visit to HOLD is one step.
  always_ff @(posedge s2clk or posedge reset) begin
    if (reset) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else begin
      if (rep_clr || !bus.push_up)
        up_cnt <= '0;
      else if (up_cnt == CW'(WRAP))
        up_cnt <= CW'(HOLD_CYCLES);
      else
        up_cnt <= up_cnt + CW'(1);

      if (rep_clr || !bus.push_down)
        down_cnt <= '0;
      else if (down_cnt == CW'(WRAP))
        down_cnt <= CW'(HOLD_CYCLES);
      else
        down_cnt <= down_cnt + CW'(1);
    end
  end

  assign up_rep   = bus.push_up & ~bus.push_down & ~rep_clr & (up_cnt == CW'(HOLD_CYCLES));
  assign down_rep = bus.push_down & ~bus.push_up & ~rep_clr & (down_cnt == CW'(HOLD_CYCLES));
`else
  logic unused_repeat_params;
  assign unused_repeat_params = (HOLD_CYCLES == 0) ^ (REPEAT_CYCLES == 0);
  assign up_rep   = 1'b0;
  assign down_rep = 1'b0;
`endif

  // Simultaneous up and down cancel.
  assign step_up   = (up_ev | up_rep) & ~(down_ev | down_rep);
  assign step_down = (down_ev | down_rep) & ~(up_ev | up_rep);

  bcd2_wrap_step u_hour_step (
    .value      (shadow_q[15:8]),
    .max_value  (HOUR_MAX),
    .up         (step_up),
    .down       (step_down),
    .next_value (hour_next)
  );

  bcd2_wrap_step u_min_step (
    .value      (shadow_q[7:0]),
    .max_value  (MIN_MAX),
    .up         (step_up),
    .down       (step_down),
    .next_value (min_next)
  );

  always_ff @(posedge s2clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      alarm_q  <= RESET_ALARM;
      shadow_q <= RESET_ALARM;
      field_q  <= FIELD_NONE;
      commit_q <= 1'b0;
      sel_d    <= 1'b0;
      up_d     <= 1'b0;
      down_d   <= 1'b0;
    end else begin
      sel_d    <= bus.push_sel;
      up_d     <= bus.push_up;
      down_d   <= bus.push_down;
      commit_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.set_en && !lock) begin
            state    <= EDIT_H;
            field_q  <= FIELD_HOUR;
            shadow_q <= alarm_q;
          end
        end
        EDIT_H, EDIT_M: begin
          if (lock) begin
            state    <= IDLE;
            field_q  <= FIELD_NONE;
            shadow_q <= alarm_q;
          end else begin
            if (step_up || step_down) begin
              if (state == EDIT_H)
                shadow_q[15:8] <= hour_next;
              else
                shadow_q[7:0] <= min_next;
            end
            // The step above lands before leaving, so a final press is still committed.
            if (!bus.set_en) begin
              state    <= COMMIT;
              field_q  <= FIELD_NONE;
              commit_q <= 1'b1;
            end else if (sel_ev) begin
              state   <= (state == EDIT_H) ? EDIT_M : EDIT_H;
              field_q <= (state == EDIT_H) ? FIELD_MIN : FIELD_HOUR;
            end
          end
        end
        COMMIT: begin
          alarm_q <= shadow_q;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          field_q <= FIELD_NONE;
        end
      endcase
    end
  end

  assign bus.alarm      = alarm_q;
  assign bus.edit_value = shadow_q;
  assign bus.edit_field = field_q;
  assign bus.commit     = commit_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed plus randomized bench for alarm_time_setter against an integer-arithmetic clock model.
module tb_alarm_time_setter;

  logic s2clk = 1'b0;
  logic reset;

  always #5 s2clk = ~s2clk;

  alarm_time_setter_if bus ();

  alarm_time_setter dut (
    .s2clk (s2clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: committed and edited time as plain integers; mode 0 idle, 1 hour, 2 minute, 3 commit.
  int   a_h, a_m, e_h, e_m, mode;
  logic m_commit;
  logic p_sel, p_up, p_dn;
`ifdef ALARM_AUTO_REPEAT_EN
  localparam int HOLD = 8;
  localparam int REP  = 4;
  int h_up, h_dn;
`endif

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    a_h = 7; a_m = 0; e_h = 7; e_m = 0;
    mode = 0; m_commit = 1'b0;
    p_sel = 1'b0; p_up = 1'b0; p_dn = 1'b0;
`ifdef ALARM_AUTO_REPEAT_EN
    h_up = 0; h_dn = 0;
`endif
  endtask

  task automatic model_step();
    logic lk, se, ue, de, ur, dr, up, dn, clr;
    lk  = (bus.alarm_state == 3'b010) || (bus.alarm_state == 3'b100);
    se  = bus.push_sel  && !p_sel;
    ue  = bus.push_up   && !p_up;
    de  = bus.push_down && !p_dn;
    clr = lk || se || !(mode == 1 || mode == 2);
    ur  = 1'b0;
    dr  = 1'b0;
`ifdef ALARM_AUTO_REPEAT_EN
    if (!clr && bus.push_up && !bus.push_down && h_up >= HOLD && (h_up - HOLD) % REP == 0)
      ur = 1'b1;
    if (!clr && bus.push_down && !bus.push_up && h_dn >= HOLD && (h_dn - HOLD) % REP == 0)
      dr = 1'b1;
    h_up = (clr || !bus.push_up)   ? 0 : h_up + 1;
    h_dn = (clr || !bus.push_down) ? 0 : h_dn + 1;
`endif
    up = (ue || ur) && !(de || dr);
    dn = (de || dr) && !(ue || ur);
    m_commit = 1'b0;
    case (mode)
      0: if (bus.set_en && !lk) begin mode = 1; e_h = a_h; e_m = a_m; end
      1, 2: begin
        if (lk) begin
          mode = 0; e_h = a_h; e_m = a_m;
        end else begin
          if (mode == 1) begin
            if (up) e_h = (e_h + 1) % 24;
            if (dn) e_h = (e_h + 23) % 24;
          end else begin
            if (up) e_m = (e_m + 1) % 60;
            if (dn) e_m = (e_m + 59) % 60;
          end
          if (!bus.set_en) begin mode = 3; m_commit = 1'b1; end
          else if (se) mode = 3 - mode;
        end
      end
      default: begin a_h = e_h; a_m = e_m; mode = 0; end
    endcase
    p_sel = bus.push_sel;
    p_up  = bus.push_up;
    p_dn  = bus.push_down;
  endtask

  task automatic tick();
    logic [1:0] fld;
    @(posedge s2clk);
    if (reset) model_reset();
    else model_step();
    @(negedge s2clk);
    fld = (mode == 1) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00;
    check_val("alarm", bus.alarm, {bcd2(a_h), bcd2(a_m)});
    check_val("edit_value", bus.edit_value, {bcd2(e_h), bcd2(e_m)});
    check_val("edit_field", {14'd0, bus.edit_field}, {14'd0, fld});
    check_val("commit", {15'd0, bus.commit}, {15'd0, m_commit});
  endtask

  task automatic press(input logic s, input logic u, input logic d);
    bus.push_sel = s; bus.push_up = u; bus.push_down = d;
    tick();
    bus.push_sel = 1'b0; bus.push_up = 1'b0; bus.push_down = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.set_en = 1'b0; bus.push_sel = 1'b0; bus.push_up = 1'b0; bus.push_down = 1'b0;
    bus.alarm_state = 3'b000;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    check_val("rst_alarm", bus.alarm, 16'h0700);
    check_val("rst_edit", bus.edit_value, 16'h0700);
    check_val("rst_field", {14'd0, bus.edit_field}, 16'h0000);

    // 07 + 3 -> 10, then commit
    bus.set_en = 1'b1;
    tick();
    check_val("enter_hour", {14'd0, bus.edit_field}, 16'h0001);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    check_val("three_up", bus.edit_value, 16'h1000);
    bus.set_en = 1'b0;
    tick();
    check_val("commit_pulse", {15'd0, bus.commit}, 16'h0001);
    tick();
    check_val("commit_clear", {15'd0, bus.commit}, 16'h0000);
    check_val("alarm_1000", bus.alarm, 16'h1000);

    // Hour and minute wrap, BCD carries and borrows
    bus.set_en = 1'b1;
    tick();
    repeat (11) press(1'b0, 1'b0, 1'b1);
    check_val("hour_23", bus.edit_value, 16'h2300);
    press(1'b0, 1'b1, 1'b0);
    check_val("hour_wrap_up", bus.edit_value, 16'h0000);
    press(1'b1, 1'b0, 1'b0);
    check_val("field_min", {14'd0, bus.edit_field}, 16'h0002);
    press(1'b0, 1'b0, 1'b1);
    check_val("min_wrap_down", bus.edit_value, 16'h0059);
    repeat (10) press(1'b0, 1'b1, 1'b0);
    check_val("min_09", bus.edit_value, 16'h0009);
    press(1'b0, 1'b1, 1'b0);
    check_val("min_carry", bus.edit_value, 16'h0010);
    press(1'b0, 1'b0, 1'b1);
    check_val("min_borrow", bus.edit_value, 16'h0009);
    press(1'b1, 1'b0, 1'b0);
    repeat (19) press(1'b0, 1'b1, 1'b0);
    check_val("hour_19", bus.edit_value, 16'h1909);
    press(1'b0, 1'b1, 1'b0);
    check_val("hour_carry", bus.edit_value, 16'h2009);

    // Lock aborts the edit without committing
    bus.alarm_state = 3'b010;
    tick();
    check_val("lock_field", {14'd0, bus.edit_field}, 16'h0000);
    check_val("lock_alarm", bus.alarm, 16'h1000);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_val("lock_ignored", bus.edit_value, 16'h1000);
    check_val("lock_alarm2", bus.alarm, 16'h1000);
    bus.alarm_state = 3'b000;
    tick();
    check_val("reenter", {14'd0, bus.edit_field}, 16'h0001);

    // up+down cancel; sel+up applies step then switches field
    press(1'b0, 1'b1, 1'b1);
    check_val("up_down_cancel", bus.edit_value, 16'h1000);
    repeat (5) press(1'b0, 1'b0, 1'b1);
    check_val("hour_05", bus.edit_value, 16'h0500);
    press(1'b1, 1'b1, 1'b0);
    check_val("sel_up_value", bus.edit_value, 16'h0600);
    check_val("sel_up_field", {14'd0, bus.edit_field}, 16'h0002);

    // Hold up for 20 cycles in the minute field
    bus.push_up = 1'b1;
    repeat (20) tick();
    bus.push_up = 1'b0;
    tick();
`ifdef ALARM_AUTO_REPEAT_EN
    check_val("hold_up", bus.edit_value, 16'h0604);
`else
    check_val("hold_up", bus.edit_value, 16'h0601);
`endif
    bus.set_en = 1'b0;
    tick();
    tick();
`ifdef ALARM_AUTO_REPEAT_EN
    check_val("hold_commit", bus.alarm, 16'h0604);
`else
    check_val("hold_commit", bus.alarm, 16'h0601);
`endif

    // Randomized phase, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 63);
      bus.alarm_state = (r == 0) ? 3'b010 : (r == 1) ? 3'b100 : (r < 32) ? 3'b000 : 3'b001;
      if ($urandom_range(0, 24) == 0) bus.set_en = ~bus.set_en;
      if ($urandom_range(0, 3) == 0) bus.push_up = ~bus.push_up;
      if ($urandom_range(0, 3) == 0) bus.push_down = ~bus.push_down;
      bus.push_sel = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
